// File: rtl/apb_requester.sv
// APB requester: accepts one command at a time, runs a SETUP/ACCESS transfer
// with a bounded PREADY wait, then holds the response until it is consumed.
module apb_requester #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_paddr,
  output logic              o_pwrite,
  output logic              o_psel,
  output logic              o_penable,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  output logic              o_busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept;
  logic             finish;
  logic             psel_d, penable_d, rsp_valid_d, cmd_ready_d, busy_d;

  // Next-state, wait counter and registered-output decode
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    accept      = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          accept    = 1'b1;
          state_nxt = SETUP;
          cnt_nxt   = '0;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
        cnt_nxt   = CNT_W'(1);
      end
      ACCESS: begin
        if (i_pready || (cnt == CNT_W'(TIMEOUT))) begin
          finish    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    psel_d      = (state_nxt == SETUP) || (state_nxt == ACCESS);
    penable_d   = (state_nxt == ACCESS);
    rsp_valid_d = (state_nxt == RESP);
    cmd_ready_d = (state_nxt == IDLE);
    busy_d      = (state_nxt != IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Control outputs track the upcoming state so they are valid in it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_psel      <= 1'b0;
      o_penable   <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_cmd_ready <= 1'b1;
      o_busy      <= 1'b0;
    end else begin
      o_psel      <= psel_d;
      o_penable   <= penable_d;
      o_rsp_valid <= rsp_valid_d;
      o_cmd_ready <= cmd_ready_d;
      o_busy      <= busy_d;
    end
  end

  // Command latch and response capture; both hold their value otherwise
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_paddr     <= '0;
      o_pwrite    <= 1'b0;
      o_pwdata    <= '0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        o_paddr  <= i_cmd_addr;
        o_pwrite <= i_cmd_write;
        o_pwdata <= i_cmd_write ? i_cmd_wdata : '0;
      end
      if (finish) begin
        o_rsp_err   <= ~i_pready;
        o_rsp_rdata <= (i_pready && !o_pwrite) ? i_prdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_apb_requester;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic              i_cmd_write;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [DATA_W-1:0] i_cmd_wdata;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [DATA_W-1:0] o_rsp_rdata;
  logic              o_rsp_err;
  logic [ADDR_W-1:0] o_paddr;
  logic              o_pwrite;
  logic              o_psel;
  logic              o_penable;
  logic [DATA_W-1:0] o_pwdata;
  logic [DATA_W-1:0] i_prdata;
  logic              i_pready;
  logic              o_busy;

  always #5 clk = ~clk;

  apb_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_paddr(o_paddr), .o_pwrite(o_pwrite), .o_psel(o_psel),
    .o_penable(o_penable), .o_pwdata(o_pwdata), .i_prdata(i_prdata), .i_pready(i_pready),
    .o_busy(o_busy)
  );

  int checks = 0;
  int errors = 0;
  int fail_prints = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Reference model: one transfer in flight, described by whether it is
  // waiting for the first APB cycle, how many ACCESS cycles have elapsed,
  // and whether a response is being offered.
  bit              m_ok = 1'b0;
  bit              m_busy, m_setup, m_resp, m_write, m_err;
  int              m_acc;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;

  always @(posedge clk) begin
    if (!rstn) begin
      m_ok = 1'b1; m_busy = 1'b0; m_setup = 1'b0; m_resp = 1'b0; m_acc = 0;
      m_addr = '0; m_write = 1'b0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
    end else if (m_ok) begin
      if (!m_busy) begin
        if (i_cmd_valid) begin
          m_busy = 1'b1; m_setup = 1'b1; m_acc = 0;
          m_addr = i_cmd_addr; m_write = i_cmd_write;
          m_wdata = i_cmd_write ? i_cmd_wdata : '0;
        end
      end else if (m_resp) begin
        if (i_rsp_ready) begin m_busy = 1'b0; m_resp = 1'b0; end
      end else if (m_setup) begin
        m_setup = 1'b0; m_acc = 1;
      end else if (i_pready) begin
        m_resp = 1'b1; m_err = 1'b0; m_rdata = m_write ? '0 : i_prdata;
      end else if (m_acc == int'(TIMEOUT)) begin
        m_resp = 1'b1; m_err = 1'b1; m_rdata = '0;
      end else begin
        m_acc++;
      end
    end
    #1;
    if (m_ok) begin
      check("cmd_ready", 64'(o_cmd_ready), 64'(!m_busy));
      check("busy",      64'(o_busy),      64'(m_busy));
      check("psel",      64'(o_psel),      64'(m_busy && !m_resp));
      check("penable",   64'(o_penable),   64'(m_busy && !m_resp && !m_setup));
      check("rsp_valid", 64'(o_rsp_valid), 64'(m_resp));
      check("paddr",     64'(o_paddr),     64'(m_addr));
      check("pwrite",    64'(o_pwrite),    64'(m_write));
      check("pwdata",    64'(o_pwdata),    64'(m_wdata));
      check("rsp_rdata", 64'(o_rsp_rdata), 64'(m_rdata));
      check("rsp_err",   64'(o_rsp_err),   64'(m_err));
    end
  end

  // Runs one transfer; reports cycles from acceptance to response and the
  // number of psel/penable cycles seen, then holds the response 'hold' cycles.
  task automatic do_xfer(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input int nwait, input logic [DATA_W-1:0] prd, input int hold,
                         output int lat, output int nsel, output int nen,
                         output logic [DATA_W-1:0] rdata, output logic err);
    int bound;
    int acc;
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_write = w; i_cmd_addr = a; i_cmd_wdata = d;
    i_pready = 1'b0; i_rsp_ready = 1'b0;
    bound = 0;
    while (!o_cmd_ready && bound < 50) begin @(negedge clk); bound++; end
    check("accept_wait", 64'(bound < 50), 64'(1));
    @(negedge clk);
    // Garbage command inputs while busy must not disturb the transfer
    i_cmd_write = 1'($urandom); i_cmd_addr = ADDR_W'($urandom); i_cmd_wdata = DATA_W'($urandom);
    lat = 1; nsel = 0; nen = 0; acc = 0;
    while (!o_rsp_valid && lat < 100) begin
      nsel += int'(o_psel);
      nen  += int'(o_penable);
      check("paddr_hold", 64'(o_paddr), 64'(a));
      if (o_penable) begin
        acc++;
        i_pready = (acc > nwait);
        i_prdata = (acc > nwait) ? prd : DATA_W'($urandom);
      end else begin
        i_pready = 1'b1;
        i_prdata = DATA_W'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    rdata = o_rsp_rdata; err = o_rsp_err;
    i_cmd_valid = 1'b0; i_pready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      i_rsp_ready = 1'b0;
      i_pready = 1'($urandom);
      @(negedge clk);
      check("hold_valid", 64'(o_rsp_valid), 64'(1));
      check("hold_rdata", 64'(o_rsp_rdata), 64'(rdata));
      check("hold_err",   64'(o_rsp_err),   64'(err));
      check("hold_ready", 64'(o_cmd_ready), 64'(0));
      check("hold_psel",  64'(o_psel),      64'(0));
    end
    i_pready = 1'b0;
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    check("idle_after_hs", 64'(o_cmd_ready), 64'(1));
    check("valid_after_hs", 64'(o_rsp_valid), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, nsel, nen, bound, t0, t1, c;
    logic [DATA_W-1:0] rd;
    logic er;
    rstn = 1'b0; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0;
    i_rsp_ready = 1'b0; i_prdata = '0; i_pready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_psel", 64'(o_psel), 64'(0));
    check("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
    check("rst_paddr", 64'(o_paddr), 64'(0));
    rstn = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 64'(o_cmd_ready), 64'(1));
    check("rst_busy", 64'(o_busy), 64'(0));

    // Zero-wait write
    do_xfer(1'b1, 8'h08, 32'h0000_0C08, 0, 32'h0, 0, lat, nsel, nen, rd, er);
    check("wr_latency", 64'(lat), 64'(3));
    check("wr_psel_cycles", 64'(nsel), 64'(2));
    check("wr_penable_cycles", 64'(nen), 64'(1));
    check("wr_rdata", 64'(rd), 64'(0));
    check("wr_err", 64'(er), 64'(0));

    // Read with two wait states
    do_xfer(1'b0, 8'h0C, 32'h1234_5678, 2, 32'hA5A5_5A5A, 0, lat, nsel, nen, rd, er);
    check("rd_latency", 64'(lat), 64'(5));
    check("rd_psel_cycles", 64'(nsel), 64'(4));
    check("rd_penable_cycles", 64'(nen), 64'(3));
    check("rd_rdata", 64'(rd), 64'(32'hA5A5_5A5A));
    check("rd_err", 64'(er), 64'(0));

    // Read that never completes
    do_xfer(1'b0, 8'h40, 32'h0, 1000, 32'hFFFF_FFFF, 0, lat, nsel, nen, rd, er);
    check("to_latency", 64'(lat), 64'(18));
    check("to_access_cycles", 64'(nen), 64'(16));
    check("to_rdata", 64'(rd), 64'(0));
    check("to_err", 64'(er), 64'(1));

    // Slow response consumer
    do_xfer(1'b0, 8'h10, 32'h0, 0, 32'hDEAD_BEEF, 5, lat, nsel, nen, rd, er);
    check("slow_rdata", 64'(rd), 64'(32'hDEAD_BEEF));

    // Reset during ACCESS aborts the transfer
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 8'h20; i_pready = 1'b0; i_rsp_ready = 1'b1;
    bound = 0;
    while (!o_penable && bound < 20) begin @(negedge clk); i_cmd_valid = 1'b0; bound++; end
    check("abort_reach_access", 64'(o_penable), 64'(1));
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("abort_psel", 64'(o_psel), 64'(0));
    check("abort_penable", 64'(o_penable), 64'(0));
    check("abort_rsp_valid", 64'(o_rsp_valid), 64'(0));
    repeat (3) begin
      @(negedge clk);
      check("abort_no_rsp", 64'(o_rsp_valid), 64'(0));
    end
    check("abort_cmd_ready", 64'(o_cmd_ready), 64'(1));

    // Back-to-back commands with a zero-wait slave and eager consumer
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 8'h30; i_prdata = 32'h0000_1111;
    i_pready = 1'b1; i_rsp_ready = 1'b1;
    t0 = -1; t1 = -1; c = 0;
    while (t1 < 0 && c < 40) begin
      @(negedge clk);
      c++;
      if (o_rsp_valid) begin
        if (t0 < 0) t0 = c; else t1 = c;
      end
    end
    i_cmd_valid = 1'b0;
    check("b2b_first", 64'(t0), 64'(3));
    check("b2b_gap", 64'(t1 - t0), 64'(4));
    repeat (3) @(negedge clk);

    // Random traffic with periodic stuck-slave windows and occasional reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rstn        = ($urandom_range(0, 199) != 0);
      i_cmd_valid = ($urandom_range(0, 2) != 0);
      i_cmd_write = 1'($urandom);
      i_cmd_addr  = ADDR_W'($urandom);
      i_cmd_wdata = DATA_W'($urandom);
      i_prdata    = DATA_W'($urandom);
      i_pready    = ((i % 400) < 120) ? 1'b0 : ($urandom_range(0, 3) == 0);
      i_rsp_ready = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    rstn = 1'b1; i_cmd_valid = 1'b0; i_rsp_ready = 1'b1; i_pready = 1'b1;
    repeat (25) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max ACCESS cycles awaiting PREADY; legal range >= 2.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_cmd_valid  input  1  command offered.
REQ-007 SHALL have port o_cmd_ready  output  1  command accepted when high with i_cmd_valid.
REQ-008 SHALL have port i_cmd_write  input  1  1=write, 0=read.
REQ-009 SHALL have port i_cmd_addr  input  ADDR_W  byte address.
REQ-010 SHALL have port i_cmd_wdata  input  DATA_W  write data.
REQ-011 SHALL have port o_rsp_valid  output  1  response available.
REQ-012 SHALL have port i_rsp_ready  input  1  response consumed when high with o_rsp_valid.
REQ-013 SHALL have port o_rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-014 SHALL have port o_rsp_err  output  1  1=transfer timed out.
REQ-015 SHALL have ports o_paddr (ADDR_W), o_pwrite (1), o_psel (1), o_penable (1), o_pwdata (DATA_W) as outputs; i_prdata (DATA_W), i_pready (1) as inputs; APB requester side.
REQ-016 SHALL have port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all outputs driven from registers.
REQ-018 IDLE: o_cmd_ready=1; on i_cmd_valid&&o_cmd_ready latch addr/write/wdata, go SETUP; o_cmd_ready=0 in all other states.
REQ-019 SETUP: o_psel=1, o_penable=0, exactly one cycle, then ACCESS unconditionally.
REQ-020 ACCESS: o_psel=1, o_penable=1; i_pready sampled only here; wait counter counts ACCESS cycles from 1.
REQ-021 ACCESS with i_pready=1: capture i_prdata into o_rsp_rdata for reads (0 for writes), o_rsp_err=0, go RESP.
REQ-022 ACCESS timeout: if i_pready=0 on the TIMEOUT-th ACCESS cycle, o_rsp_rdata=0, o_rsp_err=1, go RESP.
REQ-023 Counter width SHALL be $clog2(TIMEOUT)+1 bits, cleared on entry to SETUP; SHALL NOT wrap.
REQ-024 o_psel and o_penable SHALL both be 0 in RESP and IDLE.
REQ-025 o_paddr, o_pwrite SHALL be held constant from SETUP through final ACCESS cycle; o_pwdata = latched wdata for writes, 0 for reads.
REQ-026 o_paddr/o_pwrite/o_pwdata SHALL retain last values in IDLE/RESP.
REQ-027 RESP: o_rsp_valid=1; o_rsp_rdata/o_rsp_err stable until i_rsp_ready=1, then o_rsp_valid=0 next cycle, go IDLE.
REQ-028 Minimum latency: command accepted at cycle N, SETUP N+1, ACCESS N+2, pready at N+2 -> o_rsp_valid=1 at N+3.
REQ-029 Back-to-back: at least one IDLE cycle between response handshake and next command acceptance; max throughput one transfer per 4 cycles.
REQ-030 i_cmd_* changes while o_cmd_ready=0 SHALL have no effect on an in-flight transfer.
REQ-031 i_pready high during SETUP SHALL be ignored.

Reset
REQ-032 rstn=0 at a rising edge SHALL force state IDLE, o_psel=0, o_penable=0, o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, o_paddr=0, o_pwrite=0, o_pwdata=0, counter=0, o_busy=0; o_cmd_ready=1 on first cycle after reset release.
REQ-033 Reset during SETUP/ACCESS/RESP SHALL abort the transfer with no response produced.

Verification
REQ-034 Write addr 0x08, data 0x0000_0C08, i_pready=1 on first ACCESS -> o_psel 2 cycles, o_penable 1 cycle, o_rsp_valid at N+3, err=0, rdata=0.
REQ-035 Read addr 0x0C, i_pready low 2 ACCESS cycles then high with i_prdata=0xA5A5_5A5A -> rdata=0xA5A5_5A5A, err=0, o_rsp_valid at N+5, paddr stable throughout.
REQ-036 TIMEOUT=16, read with i_pready stuck 0 -> exactly 16 ACCESS cycles, then o_rsp_valid=1, err=1, rdata=0, o_psel=0.
REQ-037 i_rsp_ready held 0 for 5 cycles in RESP -> o_rsp_valid/rdata/err stable, o_cmd_ready=0, no APB activity; IDLE one cycle after handshake.
REQ-038 rstn=0 for one cycle during ACCESS -> next cycle o_psel=0, o_penable=0, o_rsp_valid never asserts, o_cmd_ready=1 after release.
REQ-039 i_cmd_valid held 1 with two queued commands -> second accepted only in IDLE after first response handshake; cmd_valid->rsp_valid spacing 4 cycles with zero-wait slave.
